regfile_write_arbiter: RTL and testbench

- Writer side of the CPU register file: the single source of reg_write / write_reg / write_data for the 32x32 register file.
- Merges two result sources onto the register file's single write port:
  - the in-order pipeline writeback, which has priority;
  - a long-latency unit (multiply/divide), buffered in a small valid/ready FIFO.
- Keeps a busy scoreboard of long-latency destination registers so decode can stall on RAW hazards.

---
 rtl/regfile_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: merges pipeline writeback (priority) with a
// buffered long-latency result stream, and tracks long-latency RAW hazards.
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_stall,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  chk_reg1,
  input  logic [4:0]  chk_reg2,
  output logic        busy1,
  output logic        busy2,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [4:0]    fifo_rd_d   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;

  logic        fifo_empty;
  logic        fifo_full;
  logic        force_grant;
  logic        grant_pipe;
  logic        pop;
  logic        push;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;

  // The FIFO head only competes when the pipe is idle, unless it has starved.
  always_comb begin
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CW'(DEPTH));
    force_grant = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
    grant_pipe  = pipe_valid && !force_grant;
    pop         = !grant_pipe && !fifo_empty;
    push        = mdu_valid && !fifo_full;
    head_rd     = fifo_rd_q[rd_ptr_q];
    head_data   = fifo_data_q[rd_ptr_q];
    grant_rd    = grant_pipe ? pipe_rd : head_rd;
    grant_data  = grant_pipe ? pipe_data : head_data;
  end

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = mdu_rd;
      fifo_data_d[wr_ptr_q] = mdu_data;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (grant_pipe && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // A new issue to the register being retired in the same cycle stays busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if ((grant_pipe || pop) && (grant_rd != 5'd0)) begin
      reg_write_d  = 1'b1;
      write_reg_d  = grant_rd;
      write_data_d = grant_data;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      busy_q       <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      fifo_rd_q    <= fifo_rd_d;
      fifo_data_q  <= fifo_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      busy_q       <= busy_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign mdu_ready  = !fifo_full;
  assign pipe_stall = pipe_valid && force_grant;
  assign busy1      = busy_q[chk_reg1];
  assign busy2      = busy_q[chk_reg2];
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table, corner
// sequences and random traffic against a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        res;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic        busy1;
  logic        busy2;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .res(res),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .busy1(busy1), .busy2(busy2),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data)
  );

  // Reference model: pending long-latency results as a queue, busy set as a bit array.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      m_q[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  logic s_stall, s_ready, s_busy1, s_busy2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_busy   = '0;
    m_we     = 1'b0;
    m_wreg   = '0;
    m_wdata  = '0;
  endtask

  task automatic idle_inputs();
    pipe_valid  = 1'b0; pipe_rd  = '0; pipe_data = '0;
    mdu_valid   = 1'b0; mdu_rd   = '0; mdu_data  = '0;
    issue_valid = 1'b0; issue_rd = '0;
    chk_reg1    = '0;   chk_reg2 = '0;
  endtask

  // One clock cycle: inputs already driven; checks combinational outputs at the
  // falling edge and registered outputs just after the rising edge.
  task automatic step();
    bit     frc, gp, gf, ready;
    int     pre_size;
    entry_t e;
    @(negedge clk);
    pre_size = m_q.size();
    frc   = (pre_size > 0) && (m_starve == STARVE_LIMIT);
    ready = (pre_size < DEPTH);
    s_stall = pipe_stall; s_ready = mdu_ready; s_busy1 = busy1; s_busy2 = busy2;
    check("pipe_stall", 32'(pipe_stall), 32'(pipe_valid && frc));
    check("mdu_ready",  32'(mdu_ready),  32'(ready));
    check("busy1",      32'(busy1),      32'(m_busy[chk_reg1]));
    check("busy2",      32'(busy2),      32'(m_busy[chk_reg2]));
    gp = pipe_valid && !frc;
    gf = !gp && (pre_size > 0);
    m_we = 1'b0;
    if (gp) begin
      e.rd = pipe_rd; e.data = pipe_data;
    end else if (gf) begin
      e = m_q.pop_front();
      m_busy[e.rd] = 1'b0;
    end
    if ((gp || gf) && e.rd != 0) begin
      m_we = 1'b1; m_wreg = e.rd; m_wdata = e.data;
    end
    if (pre_size == 0 || gf) m_starve = 0;
    else if (gp && m_starve < STARVE_LIMIT) m_starve++;
    if (mdu_valid && ready) begin
      e.rd = mdu_rd; e.data = mdu_data;
      m_q.push_back(e);
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
    @(posedge clk);
    #1;
    check("reg_write",  32'(reg_write), 32'(m_we));
    check("write_reg",  32'(write_reg), 32'(m_wreg));
    check("write_data", write_data,     m_wdata);
  endtask

  typedef struct {
    logic        pv;  logic [4:0] prd; logic [31:0] pdata;
    logic        mv;  logic [4:0] mrd; logic [31:0] mdata;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  chk;
    logic        e_busy; logic e_stall; logic e_ready;
    logic        e_we;   logic [4:0] e_wreg; logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[12];
  int   mdu_writes[$];
  int   stall_cnt, pipe_wr_before, acc, seen_full, k;
  bit   saw9, stalled_once;

  initial begin
    res = 1'b0;
    idle_inputs();
    model_reset();

    // Reset while a pipeline result is presented.
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_reg_write",  32'(reg_write), 32'd0);
    check("rst_write_reg",  32'(write_reg), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_mdu_ready",  32'(mdu_ready), 32'd1);
    check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    @(negedge clk);
    res = 1'b1;
    step();
    check("first_write_reg",  32'(write_reg), 32'd5);
    check("first_write_data", write_data, 32'hDEADBEEF);
    idle_inputs();
    step();

    // Directed table: busy tracking, register 0 handling, same-rd ordering.
    //          pv prd   pdata         mv mrd   mdata         iv ird   chk   busy stl rdy we wreg  wdata
    vecs[0]  = '{0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       1, 5'd7, 5'd7, 0, 0, 1, 0, 5'd5,  32'hDEADBEEF};
    vecs[1]  = '{0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 5'd7, 1, 0, 1, 0, 5'd5,  32'hDEADBEEF};
    vecs[2]  = '{0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 5'd7, 1, 0, 1, 0, 5'd5,  32'hDEADBEEF};
    vecs[3]  = '{0, 5'd0, 32'h0,       1, 5'd7, 32'h12345678, 0, 5'd0, 5'd7, 1, 0, 1, 0, 5'd5,  32'hDEADBEEF};
    vecs[4]  = '{0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 5'd7, 1, 0, 1, 1, 5'd7,  32'h12345678};
    vecs[5]  = '{0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 5'd7, 0, 0, 1, 0, 5'd7,  32'h12345678};
    vecs[6]  = '{1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hAAAA0000, 0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd7,  32'h12345678};
    vecs[7]  = '{0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd7,  32'h12345678};
    vecs[8]  = '{1, 5'd12, 32'h0C0C0C0C, 0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 0, 0, 1, 1, 5'd12, 32'h0C0C0C0C};
    vecs[9]  = '{1, 5'd12, 32'h1,      1, 5'd12, 32'h2,      0, 5'd0, 5'd0, 0, 0, 1, 1, 5'd12, 32'h1};
    vecs[10] = '{0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 5'd0, 0, 0, 1, 1, 5'd12, 32'h2};
    vecs[11] = '{0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd12, 32'h2};
    for (int i = 0; i < 12; i++) begin
      pipe_valid = vecs[i].pv; pipe_rd = vecs[i].prd; pipe_data = vecs[i].pdata;
      mdu_valid  = vecs[i].mv; mdu_rd  = vecs[i].mrd; mdu_data  = vecs[i].mdata;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      chk_reg1 = vecs[i].chk; chk_reg2 = 5'd0;
      step();
      check("vec_busy1",  32'(s_busy1),   32'(vecs[i].e_busy));
      check("vec_stall",  32'(s_stall),   32'(vecs[i].e_stall));
      check("vec_ready",  32'(s_ready),   32'(vecs[i].e_ready));
      check("vec_we",     32'(reg_write), 32'(vecs[i].e_we));
      check("vec_wreg",   32'(write_reg), 32'(vecs[i].e_wreg));
      check("vec_wdata",  write_data,     vecs[i].e_wdata);
    end
    idle_inputs();

    // Starvation: pipe busy every cycle, a single rd 9 result must be forced in.
    stall_cnt = 0; pipe_wr_before = 0; saw9 = 0; stalled_once = 0;
    for (int c = 0; c < 12; c++) begin
      pipe_valid = 1'b1; pipe_rd = 5'd1 + 5'(c % 4); pipe_data = 32'h100 + 32'(c);
      mdu_valid  = (c == 0); mdu_rd = 5'd9; mdu_data = 32'h99;
      step();
      if (s_stall) begin
        stall_cnt++;
        stalled_once = 1;
      end
      if (reg_write && write_reg == 5'd9) saw9 = 1;
      if (c >= 1 && !stalled_once) pipe_wr_before++;
    end
    check("starve_stall_cycles", 32'(stall_cnt), 32'd1);
    check("starve_pipe_before",  32'(pipe_wr_before), 32'd4);
    check("starve_rd9_written",  32'(saw9), 32'd1);
    idle_inputs();
    step();

    // Overfill: three back-to-back results with the pipe always busy.
    acc = 0; seen_full = 0; k = 0;
    mdu_writes.delete();
    while (k < 40 && mdu_writes.size() < 3) begin
      pipe_valid = 1'b1; pipe_rd = 5'd1 + 5'(k % 4); pipe_data = 32'h200 + 32'(k);
      mdu_valid  = (acc < 3); mdu_rd = 5'd20 + 5'(acc); mdu_data = 32'hA0 + 32'(acc);
      step();
      if (acc == 2 && !s_ready) seen_full = 1;
      if (mdu_valid && s_ready) acc++;
      if (reg_write && write_reg >= 5'd20) mdu_writes.push_back(int'(write_reg));
      k++;
    end
    check("overfill_ready_low", 32'(seen_full), 32'd1);
    check("overfill_count", 32'(mdu_writes.size()), 32'd3);
    if (mdu_writes.size() == 3) begin
      check("overfill_order0", 32'(mdu_writes[0]), 32'd20);
      check("overfill_order1", 32'(mdu_writes[1]), 32'd21);
      check("overfill_order2", 32'(mdu_writes[2]), 32'd22);
    end
    idle_inputs();
    step();

    // Reset mid-operation with two pending results and rd 3 busy.
    pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h55;
    issue_valid = 1'b1; issue_rd = 5'd3;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h33;
    step();
    issue_valid = 1'b0;
    mdu_rd = 5'd4; mdu_data = 32'h44;
    step();
    mdu_valid = 1'b0; chk_reg1 = 5'd3;
    step();
    check("pre_rst_busy1", 32'(busy1), 32'd1);
    check("pre_rst_ready", 32'(mdu_ready), 32'd0);
    idle_inputs();
    chk_reg1 = 5'd3;
    #2;
    res = 1'b0;
    #1;
    model_reset();
    check("midrst_ready",     32'(mdu_ready), 32'd1);
    check("midrst_busy1",     32'(busy1), 32'd0);
    check("midrst_reg_write", 32'(reg_write), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("postrst_no_write", 32'(reg_write), 32'd0);
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      pipe_valid  = ($urandom_range(0, 99) < 55);
      pipe_rd     = 5'($urandom_range(0, 31));
      pipe_data   = $urandom;
      mdu_valid   = ($urandom_range(0, 99) < 40);
      mdu_rd      = 5'($urandom_range(0, 31));
      mdu_data    = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_rd    = 5'($urandom_range(0, 31));
      chk_reg1    = 5'($urandom_range(0, 31));
      chk_reg2    = ($urandom_range(0, 1) == 1) ? mdu_rd : 5'($urandom_range(0, 31));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

endmodule
